// File: rtl/stump_control.sv
// Stump control sequencer: FETCH/EXECUTE/MEMORY cycle, instruction decode, NZVC register.
// Latency: ALU/branch ops take 2 cycles, LD/ST take 3; outputs are combinational from state and ir.
// Backpressure: none, the sequencer advances every clock.
module stump_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  flags_in,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic [2:0]  alu_func,
  output logic        c_in,
  output logic        opB_mux_sel,
  output logic        ext_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [2:0]  dest,
  output logic        reg_write,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  cc
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_MEMORY  = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic       cc_we;
  logic       cond_true;
  logic [2:0] op;
  logic       flag_n, flag_z, flag_v, flag_c;

  assign op = ir[15:13];
  assign {flag_n, flag_z, flag_v, flag_c} = cc;
  assign c_in = cc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      cc    <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (cc_we) cc <= flags_in;
    end
  end

  // Branch conditions use the registered cc only; no forwarding from flags_in.
  always_comb begin
    cond_true = 1'b0;
    case (ir[11:8])
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = 1'b0;
      4'd2:  cond_true = !flag_c && !flag_z;
      4'd3:  cond_true = flag_c || flag_z;
      4'd4:  cond_true = !flag_c;
      4'd5:  cond_true = flag_c;
      4'd6:  cond_true = !flag_z;
      4'd7:  cond_true = flag_z;
      4'd8:  cond_true = !flag_v;
      4'd9:  cond_true = flag_v;
      4'd10: cond_true = !flag_n;
      4'd11: cond_true = flag_n;
      4'd12: cond_true = (flag_n == flag_v);
      4'd13: cond_true = (flag_n != flag_v);
      4'd14: cond_true = !flag_z && (flag_n == flag_v);
      4'd15: cond_true = flag_z || (flag_n != flag_v);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = S_FETCH;
    cc_we       = 1'b0;
    fetch       = 1'b0;
    execute     = 1'b0;
    memory      = 1'b0;
    alu_func    = 3'b000;
    opB_mux_sel = 1'b0;
    ext_op      = 1'b0;
    shift_op    = 2'b00;
    srcA        = 3'd0;
    srcB        = 3'd0;
    dest        = 3'd0;
    reg_write   = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    case (state)
      S_FETCH: begin
        fetch     = 1'b1;
        mem_ren   = 1'b1;
        srcA      = 3'd7;
        reg_write = 1'b1;
        dest      = 3'd7;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        execute = 1'b1;
        if (op == 3'b111) begin
          srcA        = 3'd7;
          opB_mux_sel = 1'b1;
          ext_op      = 1'b1;
          dest        = 3'd7;
          reg_write   = cond_true;
        end else begin
          srcA = ir[7:5];
          if (ir[12]) begin
            opB_mux_sel = 1'b1;
          end else begin
            srcB     = ir[4:2];
            shift_op = ir[1:0];
          end
          // LD/ST only computes the address here; the data move happens in MEMORY.
          if (op == 3'b110) begin
            state_nxt = S_MEMORY;
          end else begin
            alu_func  = op;
            dest      = ir[10:8];
            reg_write = 1'b1;
            cc_we     = ir[11];
          end
        end
      end
      S_MEMORY: begin
        memory = 1'b1;
        if (ir[11]) begin
          mem_wen = 1'b1;
          srcA    = ir[10:8];
        end else begin
          mem_ren   = 1'b1;
          reg_write = 1'b1;
          dest      = ir[10:8];
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_stump_control.sv
// Bench for stump_control: directed literal checks plus randomized instruction stream
// compared every cycle against a phase-level model of the instruction cycle.
module tb_stump_control;

  logic        clk;
  logic        rst;
  logic [15:0] ir;
  logic [3:0]  flags_in;
  logic        fetch, execute, memory;
  logic [2:0]  alu_func;
  logic        c_in, opB_mux_sel, ext_op;
  logic [1:0]  shift_op;
  logic [2:0]  srcA, srcB, dest;
  logic        reg_write, mem_ren, mem_wen;
  logic [3:0]  cc;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  logic rand_flags = 1'b0;

  // Model: phase within the current instruction (0 fetch, 1 execute, 2 memory) and cc.
  int         mph = 0;
  logic [3:0] mcc = 4'b0000;

  stump_control dut (
    .clk(clk), .rst(rst), .ir(ir), .flags_in(flags_in),
    .fetch(fetch), .execute(execute), .memory(memory),
    .alu_func(alu_func), .c_in(c_in), .opB_mux_sel(opB_mux_sel), .ext_op(ext_op),
    .shift_op(shift_op), .srcA(srcA), .srcB(srcB), .dest(dest),
    .reg_write(reg_write), .mem_ren(mem_ren), .mem_wen(mem_wen), .cc(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Even conditions are a base predicate, odd conditions its negation.
  function automatic logic taken(input logic [3:0] c, input logic [3:0] cond);
    logic n, z, v, cy;
    logic [7:0] base;
    {n, z, v, cy} = c;
    base = {(!z && (n == v)), (n == v), !n, !v, !z, !cy, (!cy && !z), 1'b1};
    return base[cond[3:1]] ^ cond[0];
  endfunction

  function automatic logic [26:0] expect_out(input int ph, input logic [15:0] i, input logic [3:0] c);
    logic f, e, m, ob, ex, rw, rd, wr;
    logic [2:0] alu, sa, sb, d;
    logic [1:0] sh;
    {f, e, m, ob, ex, rw, rd, wr} = '0;
    {alu, sa, sb, d} = '0;
    sh = 2'b00;
    if (ph == 0) begin
      f = 1; rd = 1; sa = 7; rw = 1; d = 7;
    end else if (ph == 1) begin
      e = 1;
      if (i[15:13] == 3'd7) begin
        sa = 7; ob = 1; ex = 1; d = 7; rw = taken(c, i[11:8]);
      end else begin
        sa = i[7:5];
        ob = i[12];
        sb = i[12] ? 3'd0 : i[4:2];
        sh = i[12] ? 2'd0 : i[1:0];
        if (i[15:13] != 3'd6) begin
          alu = i[15:13]; d = i[10:8]; rw = 1;
        end
      end
    end else begin
      m = 1;
      if (i[11]) begin
        wr = 1; sa = i[10:8];
      end else begin
        rd = 1; rw = 1; d = i[10:8];
      end
    end
    return {f, e, m, alu, c[0], ob, ex, sh, sa, sb, d, rw, rd, wr, c};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mph = 0;
      mcc = 4'b0000;
    end else if (mph == 0) begin
      mph = 1;
    end else if (mph == 1) begin
      if (ir[15:13] <= 3'd5 && ir[11]) mcc = flags_in;
      mph = (ir[15:13] == 3'd6) ? 2 : 0;
    end else begin
      mph = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", {5'b0, fetch, execute, memory, alu_func, c_in, opB_mux_sel, ext_op,
                      shift_op, srcA, srcB, dest, reg_write, mem_ren, mem_wen, cc},
          {5'b0, expect_out(mph, ir, mcc)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_flags) flags_in = 4'($urandom);
  endtask

  task automatic run(input logic [15:0] i, input logic [3:0] f);
    ir = i;
    flags_in = f;
    tick();
    if (i[15:13] == 3'b110) tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ir = 16'h0000;
    flags_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch", fetch, 1);
    chk("rst_cc", cc, 0);
    chk("rst_mem_ren", mem_ren, 1);
    rst = 1'b0;
    chk_en = 1'b1;

    ir = 16'h0A04; flags_in = 4'b0101; tick();
    chk("adds_execute", execute, 1);
    chk("adds_alu", alu_func, 0);
    chk("adds_srcB", srcB, 1);
    chk("adds_we", reg_write, 1);
    chk("adds_dest", dest, 2);
    tick();
    chk("adds_cc", cc, 4'b0101);

    ir = 16'h5365; flags_in = 4'b1010; tick();
    chk("subi_opb", opB_mux_sel, 1);
    chk("subi_ext", ext_op, 0);
    chk("subi_alu", alu_func, 2);
    tick();
    chk("subi_cc", cc, 4'b0101);

    ir = 16'hC120; flags_in = 4'b1111; tick();
    chk("ld_execute", execute, 1);
    chk("ld_we_exec", reg_write, 0);
    tick();
    chk("ld_memory", memory, 1);
    chk("ld_ren", mem_ren, 1);
    chk("ld_we", reg_write, 1);
    chk("ld_dest", dest, 1);
    tick();
    chk("ld_fetch", fetch, 1);
    chk("ld_cc", cc, 4'b0101);

    ir = 16'hC920; tick(); tick();
    chk("st_wen", mem_wen, 1);
    chk("st_ren", mem_ren, 0);
    chk("st_srcA", srcA, 1);
    chk("st_we", reg_write, 0);
    tick();

    run(16'h0A04, 4'b0100);
    chk("z_cc", cc, 4'b0100);
    ir = 16'hE7FE; tick();
    chk("beq_we", reg_write, 1);
    chk("beq_dest", dest, 7);
    chk("beq_ext", ext_op, 1);
    tick();
    ir = 16'hE6FE; tick();
    chk("bne_we", reg_write, 0);
    tick();

    ir = 16'hC920; tick(); tick();
    chk("st2_memory", memory, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_fetch", fetch, 1);
    chk("midrst_wen", mem_wen, 0);
    chk("midrst_cc", cc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_fetch", fetch, 1);
    ir = 16'h0A04; flags_in = 4'b0011; tick();
    chk("post_rst_execute", execute, 1);
    tick();
    chk("post_rst_cc", cc, 4'b0011);

    for (int c = 0; c < 16; c++) begin
      run(16'h0A04, 4'(c));
      for (int k = 0; k < 16; k++) begin
        ir = {4'b1110, 4'(k), 8'h5A};
        tick();
        chk("bcc_sweep", reg_write, taken(4'(c), 4'(k)));
        tick();
      end
    end

    rand_flags = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      run(16'($urandom), 4'($urandom));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stump_control.md
# stump_control

Control sequencer for the Stump processor. Runs the three-state FETCH/EXECUTE/MEMORY cycle, decodes the latched instruction register into ALU, register-bank, shifter and memory controls, and holds the NZVC condition-code register. Branch conditions are evaluated from that register. It sits beside the Stump ALU and register bank and drives every datapath select line.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; forces FETCH and cc=0
- ir  in  16  instruction register (datapath-owned, loaded at end of FETCH)
- flags_in  in  4  ALU flags {N,Z,V,C}
- fetch / execute / memory  out  1 each  one-hot state indicators
- alu_func  out  3  ALU function code
- c_in  out  1  carry to ALU = cc[0]
- opB_mux_sel  out  1  0 = shifted register B, 1 = sign-extended immediate
- ext_op  out  1  0 = 5-bit immediate (ir[4:0]), 1 = 8-bit branch offset (ir[7:0])
- shift_op  out  2  shifter control
- srcA, srcB, dest  out  3 each  register selectors
- reg_write  out  1  register-bank write enable
- mem_ren, mem_wen  out  1 each  memory read/write strobes
- cc  out  4  condition-code register {N,Z,V,C}

## Operation
Instruction fields:
- op = ir[15:13]; type = ir[12] (1 = immediate); S/L-S/condition bit = ir[11]
- dst = ir[10:8]; A = ir[7:5]; B = ir[4:2]; shift = ir[1:0]
- Branch: cond = ir[11:8]

Outputs are combinational from state and ir. Every output not listed for a state is 0.

FETCH:
- mem_ren=1, srcA=7 (PC drives address), reg_write=1, dest=7 (PC+1 from incrementer)
- Next state: EXECUTE.

EXECUTE, op 000–101 (ADD, ADC, SUB, SBC, AND, OR):
- alu_func=op, srcA=A, dest=dst, reg_write=1
- Type 0: srcB=B, shift_op=shift, opB_mux_sel=0. Type 1: opB_mux_sel=1, ext_op=0, shift_op=0.
- If ir[11]=1, cc<=flags_in on the clock edge that leaves EXECUTE.
- Next state: FETCH.

EXECUTE, op 110 (LD/ST):
- Address calculation: alu_func=000, operands as above. No reg_write, no cc update.
- Next state: MEMORY.

EXECUTE, op 111 (Bcc):
- alu_func=000, srcA=7, opB_mux_sel=1, ext_op=1, dest=7, reg_write=cond_true. cc is never updated.
- Next state: FETCH.

Conditions 0–15, in order:
- AL(1), NV(0), HI(!C&!Z), LS(C|Z), CC(!C), CS(C), NE(!Z), EQ(Z)
- VC(!V), VS(V), PL(!N), MI(N), GE(N==V), LT(N!=V), GT(!Z&(N==V)), LE(Z|(N!=V))

MEMORY:
- ir[11]=0 (LD): mem_ren=1, reg_write=1, dest=dst
- ir[11]=1 (ST): mem_wen=1, srcA=dst (store data)
- Next state: FETCH.

## Timing
- Reset (async, any state, including mid-MEMORY): state=FETCH and cc=4'b0000 immediately. All strobes then take their FETCH values while rst is high.
- Instruction latency: ALU/branch 2 cycles (FETCH, EXECUTE); LD/ST 3 cycles.
- State register and cc update only on the rising clk edge. cc is written only at the edge ending an EXECUTE with op≠110, op≠111 and ir[11]=1.
- A flag-setting instruction followed by a branch sees the new cc in that branch's EXECUTE. No bypass is required.
- Strobes (mem_ren, mem_wen, reg_write) are never asserted simultaneously with both mem_ren and mem_wen set.
- ir must remain stable from the end of FETCH until the next FETCH; the controller never samples ir in FETCH.
- Illegal state encodings recover to FETCH on the next edge.

## Test plan
- Reset: assert rst mid-MEMORY of a ST -> fetch=1, mem_wen=0, cc=0000 before the next clock edge; the sequence resumes at FETCH after release.
- ADDS: ir=16'h0A04 (ADD, S=1, dst=2, A=0, B=1), flags_in=4'b0101 -> EXECUTE gives alu_func=000, srcB=1, reg_write=1, dest=2; cc=0101 after the edge.
- Immediate SUB without S: ir=16'h5365 -> opB_mux_sel=1, ext_op=0, alu_func=010; cc unchanged.
- LD/ST: ir=16'hC120 -> three states; MEMORY gives mem_ren=1, reg_write=1, dest=1. ir=16'hC920 -> MEMORY gives mem_wen=1, srcA=1, reg_write=0.
- Branches: with cc=0100, BEQ (ir=16'hE7FE) -> reg_write=1, dest=7, ext_op=1; BNE (ir=16'hE6FE) -> reg_write=0. Sweep all 16 conditions across all 16 cc values against the condition table.
- Back-to-back: ADDS setting Z=1, then BEQ -> the branch is taken in the very next EXECUTE.
